fir_requant_decim: RTL and testbench
====================================

Name: fir_requant_decim

Overview:
- Downstream stage of the pipelined FIR. Consumes the FIR's full-precision signed 32-bit output.
- Rounds and rescales each sample, saturates it to 16 bits, then decimates by a fixed ratio.
- Buffers results in a small FIFO behind a valid/ready output, so a stalling consumer never stalls the free-running FIR. Overflow is reported instead of back-pressuring.

Parameters:
- IN_W, 32, input sample width (FIR output width).
- OUT_W, 16, output sample width.
- SHIFT, 15, right-shift applied after rounding (Q15 coefficient scaling); legal range 1..IN_W-1.
- DECIM, 4, decimation ratio; legal range 1..256; 1 = pass every sample.
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, active-low asynchronous reset.
- din, in, IN_W, signed sample from the FIR.
- din_valid, in, 1, din qualifier; tie high when fed by a FIR that produces every cycle.
- clr_ovf, in, 1, synchronous clear of ovf and drop_cnt.
- dout, out, OUT_W, signed rescaled sample at the FIFO head.
- dout_valid, out, 1, FIFO not empty.
- dout_ready, in, 1, consumer accepts dout when dout_valid and dout_ready are both high.
- sat_pulse, out, 1, one-cycle pulse when the sample written this cycle was clipped.
- ovf, out, 1, sticky: a kept sample was dropped because the FIFO was full.
- drop_cnt, out, 16, saturating count of dropped samples.

Behaviour:
- Reset: one clock and asynchronous active-low reset; reset is asynchronous and active-low. While rst=0:
  - pipeline valids, phase counter, FIFO pointers and count, dout_valid, sat_pulse, ovf and drop_cnt are all 0;
  - dout reads 0 when the FIFO is empty.
  - Reset mid-operation discards all in-flight and buffered samples.
- Decimation:
  - phase counter runs 0..DECIM-1 and advances only on din_valid, wrapping to 0.
  - A sample is kept when din_valid=1 and phase==0. The first valid sample after reset is kept.
- Stage 1 (register):
  - r = (sign-extend din to IN_W+1 bits + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT.
  - Round-half-up toward +inf. The extra bit prevents overflow of the rounding add.
- Stage 2 (register):
  - If r > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1. If r < -2^(OUT_W-1), the result is -2^(OUT_W-1). Otherwise the result is r truncated to OUT_W.
  - Record a sat flag whenever clipping occurred.
- FIFO write:
  - The stage-2 result is written on the next edge if count < FIFO_DEPTH, or if a pop happens in the same cycle (full with simultaneous pop: both succeed, count unchanged).
  - sat_pulse is high for the cycle in which a clipped sample is presented for write, whether or not it is written.
- Drops:
  - If the FIFO is full and there is no pop, the sample is dropped.
  - A drop sets ovf and increments drop_cnt, which saturates at 0xFFFF.
  - clr_ovf clears both. A drop in the same cycle as clr_ovf wins: ovf=1, drop_cnt=1.
- Latency: sample kept at edge E0 → stage 1 at E0 → stage 2 at E1 → FIFO write at E2. dout_valid is high after E2 (3 edges, input to visible output) when the FIFO was empty.
- FIFO read:
  - Show-ahead: dout = head entry combinationally from the registered memory and pointer.
  - Pop on dout_valid & dout_ready. dout_ready while empty has no effect.
  - Simultaneous push and pop on an empty FIFO is impossible, since the push becomes visible only after the edge.
- Ordering: strict FIFO; kept samples appear in arrival order.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Test Plan:
- Rounding, SHIFT=15, DECIM=1, ready=1: din 16384 → 1; 16383 → 0; -16384 → 0; -16385 → -1; 65536 → 2. Each appears 3 edges after input, with sat_pulse=0.
- Saturation: din 0x7FFFFFFF → 32767; din 0x80000000 → -32768; din 1073758208 → 32767. sat_pulse=1 for each; ovf=0.
- Decimation, DECIM=4: din=k*32768 for k=0..11, din_valid=1 throughout → outputs 0, 4, 8 only. With din_valid low on alternate cycles, outputs are the same.
- Backpressure, DECIM=1, FIFO_DEPTH=8: hold dout_ready=0 and push 40 samples of value k*32768 → FIFO holds 0..7, ovf=1, drop_cnt=32. Raise ready → 0..7 drain in order and dout_valid falls after 8 pops. Pulse clr_ovf → ovf=0, drop_cnt=0.
- Full with simultaneous pop: FIFO full, ready=1, continuous input → no drops, count stays 8, dout sequence contiguous.
- Reset mid-stream: 5 entries buffered, drive rst=0 between edges → dout_valid=0 immediately without waiting for an edge. After release, the first valid din is kept (phase 0) and appears 3 edges later.

Source files
------------

// File: rtl/fir_requant_decim.sv
// fir_requant_decim
//   Requantiser and decimator placed behind the pipelined FIR. Each kept
//   sample is rounded half-up, shifted right by SHIFT and saturated to OUT_W
//   bits. It is then written into a show-ahead FIFO. When the FIFO is full
//   and nobody pops, the sample is dropped and counted, so the FIR is never
//   stalled.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous active-low reset
//   din        : signed IN_W-bit sample from the FIR
//   din_valid  : qualifies din; the phase counter advances only on valid
//   clr_ovf    : synchronous clear of ovf and drop_cnt
//   dout       : signed OUT_W-bit sample at the FIFO head (0 when empty)
//   dout_valid : FIFO not empty
//   dout_ready : consumer ready
//   sat_pulse  : the sample presented for write this cycle was clipped
//   ovf        : sticky; a kept sample was dropped on a full FIFO
//   drop_cnt   : saturating count of dropped samples
//
// Handshake: a transfer on the output happens on a rising edge where
// dout_valid and dout_ready are both high. dout_valid never depends on
// dout_ready. dout is stable while dout_valid is high and nothing is popped.
// dout_ready has no effect while dout_valid is low.
module fir_requant_decim #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    input  logic             clr_ovf,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             sat_pulse,
    output logic             ovf,
    output logic [15:0]      drop_cnt
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PH_W-1:0]      PH_LAST = PH_W'(DECIM - 1);
    localparam logic [AW:0]          DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [IN_W:0] RND     = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    // Bitwise inverse of +max is -max-1, the most negative OUT_W value.
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    // ---------------- decimation ----------------
    logic [PH_W-1:0] phase;
    logic            keep;

    assign keep = din_valid && (phase == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (din_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

    // ---------------- stage 1: round and shift ----------------
    // One extra bit keeps the rounding add from wrapping near +full-scale.
    logic signed [IN_W:0] din_ext;
    logic signed [IN_W:0] rnd_sum;
    logic signed [IN_W:0] r_next;
    logic signed [IN_W:0] s1_r;
    logic                 s1_valid;

    always_comb begin
        din_ext = {din[IN_W-1], din};
        rnd_sum = din_ext + RND;
        r_next  = rnd_sum >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_r <= r_next;
            end
        end
    end

    // ---------------- stage 2: saturate ----------------
    logic [OUT_W-1:0] q_next;
    logic             sat_next;
    logic [OUT_W-1:0] s2_data;
    logic             s2_sat;
    logic             s2_valid;

    always_comb begin
        q_next   = s1_r[OUT_W-1:0];
        sat_next = 1'b0;
        if (s1_r > SAT_MAX) begin
            q_next   = SAT_MAX[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (s1_r < SAT_MIN) begin
            q_next   = SAT_MIN[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sat  <= sat_next;
                s2_data <= q_next;
            end
        end
    end

    assign sat_pulse = s2_valid & s2_sat;

    // ---------------- output FIFO ----------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign dout_valid = (count != '0);
    assign full       = (count == DEPTH_C);
    assign pop        = dout_valid & dout_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push       = s2_valid & (~full | pop);
    assign drop       = s2_valid & full & ~pop;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- overflow reporting ----------------
    // A drop on the same edge as clr_ovf restarts the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fir_requant_decim.sv
// tb_fir_requant_decim
//   Drives two instances from one input stream: one with DECIM=1 and one
//   with DECIM=4. Expected outputs are computed by a reference model of the
//   rounding and saturation and are queued when a sample is driven. They are
//   popped and compared when the matching DUT hands a sample over.
module tb_fir_requant_decim;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        clr_ovf = 1'b0;

    logic [15:0] dout1, dout4;
    logic        dv1, dv4;
    logic        ready1 = 1'b1;
    logic        ready4 = 1'b1;
    logic        sat1, sat4;
    logic        ovf1, ovf4;
    logic [15:0] dc1, dc4;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp1_q[$];
    logic [15:0] exp4_q[$];
    logic [15:0] e1, e4;
    int          ph4 = 0;

    always #5 clk = ~clk;

    fir_requant_decim #(.DECIM(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_ovf(clr_ovf),
        .dout(dout1), .dout_valid(dv1), .dout_ready(ready1),
        .sat_pulse(sat1), .ovf(ovf1), .drop_cnt(dc1)
    );

    fir_requant_decim #(.DECIM(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_ovf(clr_ovf),
        .dout(dout4), .dout_valid(dv4), .dout_ready(ready4),
        .sat_pulse(sat4), .ovf(ovf4), .drop_cnt(dc4)
    );

    // Reference: floor((d + 2^14) / 2^15), clipped to 16 bits. Returns {sat, value}.
    function automatic logic [16:0] model(logic [31:0] d);
        longint x;
        x = longint'($signed(d)) + 64'sd16384;
        x = x >>> 15;
        if (x > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (x < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, x[15:0]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of input, applied 1 time unit after a rising edge.
    task automatic drive(logic [31:0] v, logic vld, bit push1);
        logic [16:0] m;
        @(posedge clk);
        #1;
        din       = v;
        din_valid = vld;
        if (vld) begin
            m = model(v);
            if (push1) exp1_q.push_back(m[15:0]);
            if (ph4 == 0) exp4_q.push_back(m[15:0]);
            ph4 = (ph4 + 1) % 4;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(32'd0, 1'b0, 1'b0);
    endtask

    // Single sample into an empty DECIM=1 FIFO with ready high: checks latency and sat_pulse.
    task automatic send_one(logic [31:0] v, logic exp_sat);
        drive(v, 1'b1, 1'b1);
        drive(32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_after_e0", dv1, 0);
        @(negedge clk);
        check("sat_pulse", sat1, exp_sat);
        check("lat_after_e1", dv1, 0);
        @(negedge clk);
        check("lat_after_e2", dv1, 1);
    endtask

    // Scoreboard monitors: compare on every accepted output.
    always @(negedge clk) begin
        if (rst && dv1 && ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL dout1_extra: observed %0h expected nothing", dout1);
            end else begin
                e1 = exp1_q.pop_front();
                check("dout1", dout1, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && dv4 && ready4) begin
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL dout4_extra: observed %0h expected nothing", dout4);
            end else begin
                e4 = exp4_q.pop_front();
                check("dout4", dout4, e4);
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_dout_valid", dv1, 0);
        check("rst_dout", dout1, 0);
        check("rst_sat_pulse", sat1, 0);
        check("rst_ovf", ovf1, 0);
        check("rst_drop_cnt", dc1, 0);
        check("rst_dout_valid4", dv4, 0);
        @(negedge clk);
        rst = 1'b1;

        // Decimation: continuous, then alternate-valid
        for (int k = 0; k < 12; k++) drive(k * 32768, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            drive(k * 32768, 1'b1, 1'b1);
            drive(32'd0, 1'b0, 1'b0);
        end
        idle(6);
        check("decim_q4_drained", exp4_q.size(), 0);
        check("decim_q1_drained", exp1_q.size(), 0);

        // Rounding
        send_one(32'd16384, 1'b0);
        send_one(32'd16383, 1'b0);
        send_one(-32'sd16384, 1'b0);
        send_one(-32'sd16385, 1'b0);
        send_one(32'd65536, 1'b0);

        // Saturation
        send_one(32'h7FFF_FFFF, 1'b1);
        send_one(32'h8000_0000, 1'b1);
        send_one(32'd1073758208, 1'b1);
        idle(2);
        check("sat_no_ovf", ovf1, 0);

        // Backpressure: only the first 8 survive
        ready1 = 1'b0;
        for (int k = 0; k < 40; k++) drive(k * 32768, 1'b1, k < 8);
        idle(4);
        check("bp_ovf", ovf1, 1);
        check("bp_drop_cnt", dc1, 32);
        check("bp_full_valid", dv1, 1);
        ready1 = 1'b1;
        idle(10);
        check("bp_drained_valid", dv1, 0);
        check("bp_q1_drained", exp1_q.size(), 0);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        check("clr_ovf", ovf1, 0);
        check("clr_drop_cnt", dc1, 0);

        // Full FIFO with simultaneous pop: ready rises so the first pop meets the first write
        ready1 = 1'b0;
        for (int k = 0; k < 8; k++) drive((100 + k) * 32768, 1'b1, 1'b1);
        idle(4);
        check("fs_full_valid", dv1, 1);
        for (int i = 0; i < 20; i++) begin
            drive((200 + i) * 32768, 1'b1, 1'b1);
            if (i == 2) ready1 = 1'b1;
        end
        idle(14);
        check("fs_drop_cnt", dc1, 0);
        check("fs_ovf", ovf1, 0);
        check("fs_drained_valid", dv1, 0);
        check("fs_q1_drained", exp1_q.size(), 0);

        // Reset mid-stream with 5 entries buffered
        ready1 = 1'b0;
        for (int k = 0; k < 5; k++) drive((300 + k) * 32768, 1'b1, 1'b0);
        idle(4);
        check("mid_buffered_valid", dv1, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", dv1, 0);
        check("mid_rst_dout", dout1, 0);
        check("mid_rst_valid4", dv4, 0);
        check("mid_rst_drop_cnt", dc1, 0);
        exp1_q.delete();
        exp4_q.delete();
        ph4 = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        ready1 = 1'b1;
        send_one(7 * 32768, 1'b0);
        idle(4);

        check("end_q1_empty", exp1_q.size(), 0);
        check("end_q4_empty", exp4_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
